// File: rtl/match_controller.sv
// Pong match sequencer: idle, serve countdown, rally, point scoring, game over.
// Define WIN_BY_TWO_EN to require a two-point lead (with saturation tie-break).
module match_controller #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               play_en,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_end,
    output logic               winner
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1);
    localparam logic [SCORE_W-1:0] MAX  = '1;
    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   LAST = CNT_W'(SERVE_DELAY - 1);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [SCORE_W-1:0] left_nxt, right_nxt;
    logic               play_nxt, breset_nxt, dir_nxt, end_nxt, winner_nxt;
    logic               right_lead, win;

    assign right_lead = score_right > score_left;

`ifdef WIN_BY_TWO_EN
    logic [SCORE_W-1:0] hi, diff;
    assign hi   = right_lead ? score_right : score_left;
    assign diff = right_lead ? score_right - score_left
                             : score_left - score_right;
    // Saturated leader wins outright; equal scores never win.
    assign win  = (score_left != score_right) &&
                  ((hi >= WIN && diff > SCORE_W'(1)) ||
                   score_left == MAX || score_right == MAX);
`else
    assign win = (score_left >= WIN) || (score_right >= WIN);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            play_en     <= 1'b0;
            ball_reset  <= 1'b0;
            serve_dir   <= 1'b1;
            score_left  <= '0;
            score_right <= '0;
            game_end    <= 1'b0;
            winner      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            play_en     <= play_nxt;
            ball_reset  <= breset_nxt;
            serve_dir   <= dir_nxt;
            score_left  <= left_nxt;
            score_right <= right_nxt;
            game_end    <= end_nxt;
            winner      <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        play_nxt   = play_en;
        breset_nxt = 1'b0;
        dir_nxt    = serve_dir;
        left_nxt   = score_left;
        right_nxt  = score_right;
        end_nxt    = game_end;
        winner_nxt = winner;
        unique case (state)
            IDLE: begin
                if (start_btn) begin
                    left_nxt   = '0;
                    right_nxt  = '0;
                    dir_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    breset_nxt = 1'b1;
                    state_nxt  = SERVE;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        play_nxt  = 1'b1;
                        state_nxt = PLAY;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (miss_left || miss_right) begin
                    play_nxt  = 1'b0;
                    state_nxt = POINT;
                end
                // A double miss is a replay: no score, direction kept.
                if (miss_left && !miss_right) begin
                    if (score_right != MAX)
                        right_nxt = score_right + 1'b1;
                    dir_nxt = 1'b0;
                end else if (miss_right && !miss_left) begin
                    if (score_left != MAX)
                        left_nxt = score_left + 1'b1;
                    dir_nxt = 1'b1;
                end
            end
            POINT: begin
                if (win) begin
                    end_nxt    = 1'b1;
                    winner_nxt = right_lead;
                    state_nxt  = OVER;
                end else begin
                    breset_nxt = 1'b1;
                    state_nxt  = SERVE;
                end
            end
            OVER: begin
                if (start_btn) begin
                    left_nxt   = '0;
                    right_nxt  = '0;
                    end_nxt    = 1'b0;
                    dir_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    breset_nxt = 1'b1;
                    state_nxt  = SERVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: randomized rallies against a
// point-level reference model of the match rules.
module tb_match_controller;

    localparam int WIN  = 7;
    localparam int DLY  = 60;
    localparam int SW   = 4;
    localparam int MAXV = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic          miss_left = 1'b0;
    logic          miss_right = 1'b0;
    logic          play_en, ball_reset, serve_dir, game_end, winner;
    logic [SW-1:0] score_left, score_right;

    match_controller #(
        .WIN_SCORE(WIN), .SERVE_DELAY(DLY), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .start_btn(start_btn), .miss_left(miss_left),
        .miss_right(miss_right), .play_en(play_en),
        .ball_reset(ball_reset), .serve_dir(serve_dir),
        .score_left(score_left), .score_right(score_right),
        .game_end(game_end), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l;
        int r;
        int dir;
        int ge;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: match state at point granularity.
    int   m_l, m_r, m_dir, m_over, m_win;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int rule_over(input int l, input int r);
        int hi, lead;
        hi   = (l > r) ? l : r;
        lead = (l > r) ? l - r : r - l;
`ifdef WIN_BY_TWO_EN
        if (l == r) return 0;
        return ((hi >= WIN && lead >= 2) || l == MAXV || r == MAXV) ? 1 : 0;
`else
        return (hi >= WIN) ? 1 : 0;
`endif
    endfunction

    function automatic void model_new_game();
        m_l = 0; m_r = 0; m_dir = 1; m_over = 0; m_win = 0;
    endfunction

    // kind: 0 = left miss, 1 = right miss, 2 = both
    function automatic void model_point(input int kind);
        if (kind == 0) begin
            if (m_r < MAXV) m_r++;
            m_dir = 0;
        end else if (kind == 1) begin
            if (m_l < MAXV) m_l++;
            m_dir = 1;
        end
        m_over = rule_over(m_l, m_r);
        m_win  = (m_r > m_l) ? 1 : 0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.l = m_l; e.r = m_r; e.dir = m_dir; e.ge = m_over; e.win = m_win;
        exp_q.push_back(e);
    endfunction

    // Monitor: every ball_reset pulse or game_end rise consumes one entry.
    logic prev_br = 1'b0;
    logic prev_ge = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_br = 1'b0;
            prev_ge = 1'b0;
        end else begin
            if (ball_reset && prev_br)
                chk("ball_reset_single", 1, 0);
            if (ball_reset || (game_end && !prev_ge)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: event with empty queue at %0t",
                             $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_score_left", int'(score_left), e.l);
                    chk("sb_score_right", int'(score_right), e.r);
                    chk("sb_serve_dir", int'(serve_dir), e.dir);
                    chk("sb_game_end", int'(game_end), e.ge);
                    if (e.ge != 0) chk("sb_winner", int'(winner), e.win);
                end
            end
            prev_br = ball_reset;
            prev_ge = game_end;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        model_new_game();
        push_exp();
        start_btn  = 1'b1;
        frame_tick = 1'($urandom % 2);
        step();
        start_btn  = 1'b0;
        frame_tick = 1'b0;
        chk("start_ball_reset", int'(ball_reset), 1);
        chk("start_game_end", int'(game_end), 0);
        chk("start_play_en", int'(play_en), 0);
    endtask

    // Countdown with ignored noise; stop_at > 0 aborts after that tick.
    task automatic do_serve(input int stop_at);
        int gap;
        for (int t = 1; t <= DLY; t++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                miss_left  = ($urandom % 8 == 0);
                miss_right = ($urandom % 8 == 0);
                start_btn  = ($urandom % 8 == 0);
                step();
            end
            miss_left = 1'b0; miss_right = 1'b0; start_btn = 1'b0;
            if (play_en) chk("play_en_early", int'(play_en), 0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (t == stop_at) return;
        end
        chk("play_en_rise", int'(play_en), 1);
        chk("serve_score_left", int'(score_left), m_l);
        chk("serve_score_right", int'(score_right), m_r);
    endtask

    task automatic do_point(input int kind);
        repeat ($urandom_range(0, 3)) begin
            start_btn = 1'($urandom % 2);
            step();
            chk("play_en_hold", int'(play_en), 1);
        end
        start_btn  = 1'b0;
        miss_left  = (kind != 1);
        miss_right = (kind != 0);
        step();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        model_point(kind);
        chk("pt_score_left", int'(score_left), m_l);
        chk("pt_score_right", int'(score_right), m_r);
        chk("pt_serve_dir", int'(serve_dir), m_dir);
        chk("pt_play_en_drop", int'(play_en), 0);
        push_exp();
        step();
        if (m_over != 0) begin
            chk("pt_game_end", int'(game_end), 1);
            chk("pt_winner", int'(winner), m_win);
        end else begin
            chk("pt_ball_reset", int'(ball_reset), 1);
            chk("pt_no_end", int'(game_end), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_play_en"}, int'(play_en), 0);
        chk({tag, "_ball_reset"}, int'(ball_reset), 0);
        chk({tag, "_game_end"}, int'(game_end), 0);
        chk({tag, "_winner"}, int'(winner), 0);
        chk({tag, "_serve_dir"}, int'(serve_dir), 1);
        chk({tag, "_score_left"}, int'(score_left), 0);
        chk({tag, "_score_right"}, int'(score_right), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, n;
        model_new_game();
        repeat (3) step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();
        check_reset_outputs("idle");

        // Left wins 7 straight, then OVER ignores misses.
        do_start();
        for (int i = 0; i < WIN; i++) begin
            do_serve(0);
            do_point(1);
        end
        chk("straight_game_end", int'(game_end), 1);
        chk("straight_score_left", int'(score_left), WIN);
        repeat (4) begin
            miss_left  = 1'($urandom % 2);
            miss_right = 1'b1;
            step();
        end
        miss_left = 1'b0; miss_right = 1'b0;
        step();
        chk("over_hold_left", int'(score_left), WIN);
        chk("over_hold_right", int'(score_right), 0);
        chk("over_hold_end", int'(game_end), 1);
        chk("over_play_en", int'(play_en), 0);

        // Restart from OVER, mix a replay in, reach 3/2, reset mid-countdown.
        do_start();
        chk("restart_score_left", int'(score_left), 0);
        do_serve(0); do_point(1);
        do_serve(0); do_point(2);
        do_serve(0); do_point(1);
        do_serve(0); do_point(1);
        do_serve(0); do_point(0);
        do_serve(0); do_point(0);
        chk("pre_rst_left", int'(score_left), 3);
        chk("pre_rst_right", int'(score_right), 2);
        do_serve(DLY / 2);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst = 1'b0;
        exp_q.delete();
        model_new_game();
        step();
        do_start();
        do_serve(0);

        // Alternate to 6/6, then left pulls ahead.
        for (int i = 0; i < 12; i++) begin
            do_point((i % 2 == 0) ? 1 : 0);
            do_serve(0);
        end
        do_point(1);
        if (m_over == 0) begin
            do_serve(0);
            do_point(1);
        end
        chk("lead_game_end", int'(game_end), 1);
        chk("lead_winner", int'(winner), 0);

        // Random matches.
        for (int g = 0; g < 4; g++) begin
            do_start();
            n = 0;
            while (m_over == 0 && n < 60) begin
                do_serve(0);
                kind = ($urandom % 8 == 0) ? 2 : int'($urandom % 2);
                do_point(kind);
                n++;
            end
            chk("rand_game_end", int'(game_end), m_over);
        end

        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
